// File: rtl/seven_seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
// Macro LEADING_ZERO_BLANK_EN (used by seven_seg_scan_ctrl) enables leading-zero suppression.
package seven_seg_scan_pkg;

  localparam int unsigned BCD_W           = 4;
  localparam int unsigned DEF_NUM_DIGITS  = 4;
  localparam int unsigned DEF_REFRESH_DIV = 50000;
  localparam int unsigned DEF_BLANK_CYC   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  // Bits needed to hold a count from 0 to max_val-1.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 2) begin
      return 1;
    end
    return 32'($clog2(max_val));
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_scan_prescaler.sv
// Slot timer: counts cycles within a scan state and flags the terminal count.
module scan_prescaler #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_c
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc_c = enable_i && (count_q == term_i);

  // Self-wraps at terminal count so back-to-back slots need no extra clear.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = tc_c ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed BCD digit scanner with blanking guard and frame-aligned display update.
// Optional leading-zero suppression is built when LEADING_ZERO_BLANK_EN is defined.
module seven_seg_scan_ctrl
  import seven_seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int unsigned REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int unsigned BLANK_CYC   = DEF_BLANK_CYC
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
  output logic [BCD_W-1:0]            bcd_out,
  output logic [NUM_DIGITS-1:0]       digit_sel,
  output logic                        frame_done
);

  localparam int unsigned DATA_W     = BCD_W * NUM_DIGITS;
  localparam int unsigned IDX_W      = 32'($clog2(NUM_DIGITS));
  localparam int unsigned CNT_W      = cnt_width(REFRESH_DIV);
  localparam int unsigned SHOW_TERM  = REFRESH_DIV - 1;
  localparam int unsigned BLANK_TERM = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [DATA_W-1:0]     pending_q, pending_d;
  logic [DATA_W-1:0]     active_q, active_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  fd_q, fd_d;

  logic                  slot_tc;
  logic                  pre_clear;
  logic [CNT_W-1:0]      pre_term;
  logic [IDX_W-1:0]      idx_nxt;
  logic                  wrap;
  logic                  copy;
  logic [NUM_DIGITS-1:0] lit;
`ifdef LEADING_ZERO_BLANK_EN
  logic                  nz_above;
`endif

  assign pre_clear = (state_q == ST_IDLE) || !enable;
  assign pre_term  = (state_q == ST_BLANK) ? CNT_W'(BLANK_TERM) : CNT_W'(SHOW_TERM);
  assign wrap      = (index_q == IDX_W'(NUM_DIGITS - 1));
  assign idx_nxt   = wrap ? '0 : index_q + IDX_W'(1);

  scan_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (pre_clear),
    .enable_i (1'b1),
    .term_i   (pre_term),
    .tc_c     (slot_tc)
  );

  // Next-state, data registers and registered outputs.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    pending_d = load ? digits_in : pending_q;
    active_d  = active_q;
    bcd_d     = bcd_q;
    sel_d     = '0;
    fd_d      = 1'b0;
    copy      = 1'b0;
    lit       = '1;
`ifdef LEADING_ZERO_BLANK_EN
    nz_above  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SHOW;
          index_d = '0;
          copy    = 1'b1;
        end
      end
      ST_SHOW: begin
        if (slot_tc) begin
          if (BLANK_CYC == 0) begin
            index_d = idx_nxt;
            copy    = wrap;
            fd_d    = wrap;
          end else begin
            state_d = ST_BLANK;
          end
        end
      end
      ST_BLANK: begin
        if (slot_tc) begin
          state_d = ST_SHOW;
          index_d = idx_nxt;
          copy    = wrap;
          fd_d    = wrap;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping enable aborts the frame; digit data is retained.
    if (!enable) begin
      state_d = ST_IDLE;
      index_d = '0;
      copy    = 1'b0;
      fd_d    = 1'b0;
    end

    // A load on a copy edge bypasses pending so it shows in this frame.
    if (copy) begin
      active_d = load ? digits_in : pending_q;
    end

`ifdef LEADING_ZERO_BLANK_EN
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      nz_above = nz_above || (active_d[i*BCD_W +: BCD_W] != '0);
      lit[i]   = nz_above;
    end
`endif

    if (state_d == ST_SHOW) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (index_d == IDX_W'(i)) begin
          bcd_d    = active_d[i*BCD_W +: BCD_W];
          sel_d[i] = lit[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      pending_q <= '0;
      active_q  <= '0;
      bcd_q     <= '0;
      sel_q     <= '0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      bcd_q     <= bcd_d;
      sel_q     <= sel_d;
      fd_q      <= fd_d;
    end
  end

  assign bcd_out    = bcd_q;
  assign digit_sel  = sel_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed self-checking bench for seven_seg_scan_ctrl (4 digits, 4-cycle slots, 1-cycle blank).
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLANK_CYC   (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .digits_in  (digits_in),
    .bcd_out    (bcd_out),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full frame: 4 slots of 4 lit cycles plus 1 blank cycle each.
  // Optionally raises load for one edge right after sampling (ld_slot, ld_cyc).
  task automatic frame(input logic [15:0] shown, input bit first, input logic [3:0] lit,
                       input int ld_slot, input int ld_cyc, input logic [15:0] ld_val);
    logic [3:0] nib;
    logic [3:0] exp_sel;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 5; c++) begin
        step();
        load = 1'b0;
        nib  = shown[s*4 +: 4];
        if (c < 4) begin
          exp_sel = lit[s] ? (4'b0001 << s) : 4'b0000;
          check($sformatf("sel d%0d c%0d", s, c), 32'(digit_sel), 32'(exp_sel));
          if (lit[s]) check($sformatf("bcd d%0d c%0d", s, c), 32'(bcd_out), 32'(nib));
          if (!(first && s == 0 && c == 0))
            check($sformatf("fd d%0d c%0d", s, c), 32'(frame_done), 32'(s == 0 && c == 0));
        end else begin
          check($sformatf("blank sel d%0d", s), 32'(digit_sel), 32'd0);
          check($sformatf("blank fd d%0d", s), 32'(frame_done), 32'd0);
          if (lit[s]) check($sformatf("blank bcd d%0d", s), 32'(bcd_out), 32'(nib));
        end
        if (s == ld_slot && c == ld_cyc) begin
          load      = 1'b1;
          digits_in = ld_val;
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    load      = 1'b0;
    digits_in = 16'h0000;
    step();
    step();
    check("rst sel", 32'(digit_sel), 32'd0);
    check("rst bcd", 32'(bcd_out), 32'd0);
    check("rst fd", 32'(frame_done), 32'd0);

    reset     = 1'b0;
    enable    = 1'b0;
    load      = 1'b1;
    digits_in = 16'h1234;
    step();
    load = 1'b0;
    check("idle sel", 32'(digit_sel), 32'd0);

    enable = 1'b1;
    frame(16'h1234, 1'b1, 4'hF, -1, -1, 16'h0000);
    frame(16'h1234, 1'b0, 4'hF, 2, 1, 16'h5678);
    frame(16'h5678, 1'b0, 4'hF, 3, 4, 16'h9999);

    // Wrap-cycle load shows immediately, then enable drop in digit 1.
    step();
    load = 1'b0;
    check("wrap ld sel", 32'(digit_sel), 32'h1);
    check("wrap ld bcd", 32'(bcd_out), 32'h9);
    check("wrap ld fd", 32'(frame_done), 32'd1);
    repeat (4) step();
    step();
    check("d1 c0 sel", 32'(digit_sel), 32'h2);
    step();
    check("d1 c1 sel", 32'(digit_sel), 32'h2);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("drop sel %0d", k), 32'(digit_sel), 32'd0);
      check($sformatf("drop fd %0d", k), 32'(frame_done), 32'd0);
    end
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("reen sel %0d", k), 32'(digit_sel), 32'h1);
      check($sformatf("reen bcd %0d", k), 32'(bcd_out), 32'h9);
    end
    step();
    check("reen blank", 32'(digit_sel), 32'd0);

    // Mid-frame reset clears outputs and stored digits at the next edge.
    step();
    check("pre rst sel", 32'(digit_sel), 32'h2);
    reset = 1'b1;
    load      = 1'b1;
    digits_in = 16'h4321;
    step();
    reset = 1'b0;
    load  = 1'b0;
    check("mid rst sel", 32'(digit_sel), 32'd0);
    check("mid rst bcd", 32'(bcd_out), 32'd0);
    check("mid rst fd", 32'(frame_done), 32'd0);
    step();
    check("post rst sel", 32'(digit_sel), 32'h1);
    check("post rst bcd", 32'(bcd_out), 32'd0);

`ifdef LEADING_ZERO_BLANK_EN
    enable = 1'b0;
    step();
    load      = 1'b1;
    digits_in = 16'h0070;
    step();
    load   = 1'b0;
    enable = 1'b1;
    frame(16'h0070, 1'b1, 4'b0011, -1, -1, 16'h0000);
    enable = 1'b0;
    step();
    load      = 1'b1;
    digits_in = 16'h0000;
    step();
    load   = 1'b0;
    enable = 1'b1;
    frame(16'h0000, 1'b1, 4'b0001, -1, -1, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 Parameter REFRESH_DIV, default 50000: clock cycles each digit is lit per scan slot, minimum 1.
REQ-003 Parameter BLANK_CYC, default 16: all-off guard cycles after each digit slot, range 0..REFRESH_DIV.
REQ-004 clk  input  1  single clock; all logic SHALL be clocked on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  scanning runs while high.
REQ-007 load  input  1  one-cycle strobe that captures digits_in.
REQ-008 digits_in  input  4*NUM_DIGITS  packed BCD nibbles; nibble 0 is the least-significant digit.
REQ-009 bcd_out  output  4  nibble for the current digit, driven to the external BCD-to-7-segment decoder.
REQ-010 digit_sel  output  NUM_DIGITS  one-hot, active-high digit enable; all zeros means dark.
REQ-011 frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-012 State machine SHALL have three states: IDLE, SHOW and BLANK.
- IDLE: digit_sel=0; index=0; prescaler=0.
- IDLE->SHOW when enable=1.
REQ-013 SHOW SHALL last exactly REFRESH_DIV cycles.
- digit_sel = one-hot(index); bcd_out = active[index].
REQ-014 BLANK SHALL last exactly BLANK_CYC cycles.
- digit_sel=0; bcd_out holds its last value.
- BLANK_CYC=0: SHOW goes directly to the next SHOW.
REQ-015 At the end of each slot, index SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0.
- Frame period = NUM_DIGITS*(REFRESH_DIV+BLANK_CYC) cycles.
REQ-016 frame_done SHALL be high for exactly one cycle: the first SHOW cycle after the wrap to index 0.
REQ-017 load SHALL write digits_in into the pending register on the same edge.
REQ-018 pending SHALL be copied to active only on these edges:
- the edge entering SHOW with index 0 (frame wrap);
- the IDLE->SHOW edge.
- The displayed value SHALL never change mid-frame.
REQ-019 If load coincides with a copy edge, digits_in SHALL go straight into active, so the new value shows that frame.
REQ-020 If enable=0 in any cycle, the next cycle SHALL be IDLE.
- digit_sel=0; index=0; prescaler=0.
- pending and active are retained.
- Re-enable SHALL start a full REFRESH_DIV slot on digit 0.
REQ-021 Nibbles greater than 9 SHALL be passed to bcd_out unchanged.
REQ-022 At most one bit of digit_sel SHALL be high in any cycle.

Reset
REQ-023 With reset high at a clock edge, the block SHALL enter IDLE.
- digit_sel=0, bcd_out=0, frame_done=0.
- pending=0, active=0, index=0, prescaler=0.
REQ-024 Reset SHALL override enable and load.
- A reset mid-frame SHALL take effect on the next edge, with no partial slot.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN controls leading-zero suppression.
- Defined: during the slot of digit i (i>0), digit_sel SHALL be 0 if active[i] and every more-significant nibble are 0; digit 0 is never suppressed.
- Slot timing and frame_done SHALL be unchanged.
- Undefined: every digit SHALL be lit in its slot.

Structure
REQ-026 Package seven_seg_scan_pkg SHALL hold:
- the state encoding (IDLE, SHOW, BLANK);
- default parameter constants;
- the BCD nibble width constant (4).
REQ-027 The slot timer SHALL be a sub-module, scan_prescaler.
- Inputs: clear, enable.
- Output: a terminal-count pulse, with a per-state terminal value.
REQ-028 The 7-segment decoder SHALL remain external; this block SHALL NOT instantiate it.

Verification (bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1)
REQ-029 Reset: reset=1 for 2 cycles with enable=1 -> digit_sel=0000, bcd_out=0, frame_done=0.
REQ-030 Basic scan: load 16'h1234, then enable=1 ->
- (digit_sel, bcd_out) = 0001/4 x4 cycles, 0000 x1, 0010/3 x4, 0000 x1, 0100/2 x4, 0000 x1, 1000/1 x4, 0000 x1;
- then frame_done=1 with digit_sel=0001.
REQ-031 Mid-frame load: while showing 1234, load 16'h5678 during digit 2 ->
- digit 2 shows 2 and digit 3 shows 1;
- the next frame shows 8, 7, 6, 5.
REQ-032 Load on the wrap cycle: load 16'h9999 on the edge entering index 0 -> bcd_out=9 in that same slot.
REQ-033 Enable drop: enable=0 in the 2nd cycle of digit 1, then 1 three cycles later ->
- digit_sel=0000 the cycle after the drop;
- after re-enable, 0001 for a full 4 cycles.
REQ-034 With LEADING_ZERO_BLANK_EN defined:
- load 16'h0070 -> digits 3 and 2 dark, digit 1 shows 7, digit 0 shows 0;
- load 16'h0000 -> only digit 0 is lit.
